fmc_link_master: RTL
====================

Name: fmc_link_master

Overview:
- FPGA-side sequencer that drives the FMC pins of the test chip: chip reset release, config / write / read bursts over the 128-bit bidirectional bus, the divided transfer clock, and the strobe pins.
- Sits between host-side command/data streams and the top-level pad wrapper.
- The pad wrapper owns the tri-state on IO_spi_data (drive O_bus_out when O_bus_oe=1, return pad value on I_bus_in) and wires the static mode pins.

Parameters:
DW, 128, bus word width
LEN_W, 8, burst length field width (burst = len+1 words)
SCK_DIV, 4, clk cycles per O_spi_sck half-period (>=2)
RST_CYC, 64, clk cycles chip reset is held low after I_rst_n release
TURN_CYC, 4, idle clk cycles with bus undriven before and after a read burst

Ports:
I_clk  in  1  system clock
I_rst_n  in  1  asynchronous active-low reset
I_cmd_val  in  1  command valid
O_cmd_rdy  out  1  command accepted when val&rdy
I_cmd_op  in  2  00 config, 01 write, 10 read, 11 reserved (completes immediately as 0-word no-op)
I_cmd_len  in  LEN_W  words-1
I_wdata  in  DW  host write/config word
I_wdata_val  in  1  write word valid
O_wdata_rdy  out  1  holding register empty
O_rdata  out  DW  captured read word
O_rdata_val  out  1  read word valid
I_rdata_rdy  in  1  host accepts read word
O_bus_out  out  DW  bus drive value
O_bus_oe  out  1  FPGA drives bus
I_bus_in  in  DW  bus pad value
O_reset_n  out  1  chip reset
O_spi_sck  out  1  transfer clock
O_spi_cs_n  out  1  config-ready strobe, low during config burst
O_in_1  out  1  write-ready strobe, high during write burst
O_in_2  out  1  read-valid strobe, high during read burst
O_OE_req  out  1  chip pad-output request, high from read turnaround start to end
O_busy  out  1  state != IDLE or reset hold active

Behaviour:
- Reset values:
  - O_reset_n=0, O_spi_sck=0, O_spi_cs_n=1, O_in_1=0, O_in_2=0, O_OE_req=0.
  - O_bus_oe=0, O_bus_out=0, O_rdata_val=0, O_rdata=0.
  - O_cmd_rdy=0, O_wdata_rdy=1, O_busy=1.
- Reset hold: counter runs RST_CYC cycles after I_rst_n deasserts, then O_reset_n=1. O_cmd_rdy stays 0 until the cycle after.
- States:
  - RSTHOLD -> IDLE.
  - IDLE: O_cmd_rdy=1; on accept, latch op/len, go to XFER (config/write) or TURN_IN (read).
  - XFER: sends len+1 words, then DONE.
  - TURN_IN: TURN_CYC cycles -> RD.
  - RD: reads len+1 words, then TURN_OUT.
  - TURN_OUT: TURN_CYC cycles -> DONE.
  - DONE: one cycle, all strobes inactive -> IDLE.
  - Op 11 goes IDLE -> DONE.
- SCK generation:
  - Divider counts 0..SCK_DIV-1 only in XFER/RD; each wrap toggles O_spi_sck. One word per full sck period.
  - "Fall event" = wrap with sck=1; "rise event" = wrap with sck=0.
  - Outside XFER/RD sck=0 and divider=0.
- XFER:
  - O_bus_oe=1. O_spi_cs_n=0 for config; O_in_1=1 for write.
  - Word k goes to O_bus_out on entry (k=0) or at the fall event ending word k-1.
  - A 1-word holding register sits behind I_wdata/O_wdata_rdy.
  - If the register is empty when a word must load, sck freezes low and the divider holds until data arrives. Loading the word restarts the divider.
  - After the last word's fall event: bus_oe=0, strobes inactive.
- RD:
  - O_bus_oe=0, O_OE_req=1 through TURN_IN/RD/TURN_OUT, O_in_2=1 in RD only.
  - At each rise event I_bus_in is captured into O_rdata with O_rdata_val=1; held until I_rdata_rdy.
  - If O_rdata_val=1 and !I_rdata_rdy at a fall event, sck freezes low until accepted. No word is dropped or overwritten.
- Simultaneous: rdata accept and a new capture in the same cycle -> new word valid.
- Write data arriving outside a write/config burst stays in the holding register for the next burst.
- I_rst_n assert mid-burst: all outputs asynchronously return to reset values. The chip is re-reset via O_reset_n=0 and the holding register is cleared.

Optional Feature:
FMC_XFER_CNT_EN:
- Defined: adds O_wr_cnt[31:0] and O_rd_cnt[31:0], saturating counts of words sent (config+write) and words captured, cleared by reset only.
- Undefined: ports and logic absent.

Decomposition:
- Package fmc_link_pkg: op encodings, state enum, default parameter constants.
- Sub-module fmc_sck_gen (divider, freeze input, rise/fall event outputs).

Test Plan:
- Reset release, RST_CYC=64 -> O_reset_n rises at cycle 64, O_cmd_rdy=1 at cycle 65, no sck activity.
- Config op, len=2, words A,B,C pre-supplied, SCK_DIV=4 -> cs_n low 3 sck periods (24 clks); bus shows A,B,C, each stable across its rise event; cs_n returns high, DONE, IDLE.
- Write len=1 with second word delayed 20 clks -> sck frozen low during the gap, O_in_1 stays 1, word 2 sent after arrival; total 2 rise events.
- Read len=3, chip model drives 0x11..0x44 -> O_OE_req high 4 clks before first sck, captured 0x11,0x22,0x33,0x44 in order, bus_oe=0 throughout.
- Read with I_rdata_rdy low for 30 clks after word 0 -> sck frozen; on release, words 1..3 follow with none lost.
- I_rst_n pulse mid-write -> outputs to reset values immediately, O_reset_n low, RST_CYC hold repeated, new command completes normally.

Source files
------------

// File: rtl/fmc_link_pkg.sv
// fmc_link_pkg
// Shared definitions for the FMC link master: command op encodings, the
// sequencer state enum and the default parameter values.
// Optional build macro used by the slice: FMC_XFER_CNT_EN (word counters).
package fmc_link_pkg;

    localparam int DW_DEF       = 128;
    localparam int LEN_W_DEF    = 8;
    localparam int SCK_DIV_DEF  = 4;
    localparam int RST_CYC_DEF  = 64;
    localparam int TURN_CYC_DEF = 4;

    typedef enum logic [1:0] {
        OP_CFG = 2'b00,
        OP_WR  = 2'b01,
        OP_RD  = 2'b10,
        OP_NOP = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_RSTHOLD  = 3'd0,
        ST_IDLE     = 3'd1,
        ST_XFER     = 3'd2,
        ST_TURN_IN  = 3'd3,
        ST_RD       = 3'd4,
        ST_TURN_OUT = 3'd5,
        ST_DONE     = 3'd6
    } state_e;

endpackage

// File: rtl/fmc_link_master_sck.sv
// fmc_sck_gen
// Transfer clock divider. While enabled, a counter runs 0..SCK_DIV-1 and each
// wrap toggles sck, giving one sck period per 2*SCK_DIV clk cycles.
// Ports:
//   clk, rst_n   - system clock, asynchronous active-low reset
//   en           - divider runs only while high; low forces sck=0, div=0
//   freeze       - holds divider and sck (only asserted while sck is low)
//   sck          - divided transfer clock
//   rise_ev      - single-cycle pulse on the wrap that drives sck 0->1
//   fall_ev      - single-cycle pulse on the wrap that drives sck 1->0
//   phase_zero   - sck low with divider at 0 (start of a word period)
module fmc_sck_gen #(
    parameter int SCK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic freeze,
    output logic sck,
    output logic rise_ev,
    output logic fall_ev,
    output logic phase_zero
);

    localparam int CW = $clog2(SCK_DIV);

    logic [CW-1:0] div;
    logic          wrap;

    assign wrap       = en && !freeze && (div == CW'(SCK_DIV - 1));
    assign rise_ev    = wrap && !sck;
    assign fall_ev    = wrap && sck;
    assign phase_zero = !sck && (div == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
            sck <= 1'b0;
        end else if (!en) begin
            div <= '0;
            sck <= 1'b0;
        end else if (!freeze) begin
            if (wrap) begin
                div <= '0;
                sck <= ~sck;
            end else begin
                div <= div + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fmc_link_master.sv
// fmc_link_master
// FPGA-side sequencer for the test chip FMC pins: holds the chip in reset
// for RST_CYC cycles, then runs config/write bursts (FPGA drives the bus)
// and read bursts (chip drives the bus, framed by turnaround gaps) clocked
// by the divided transfer clock O_spi_sck.
//
// Ports:
//   I_clk, I_rst_n                 - clock, asynchronous active-low reset
//   I_cmd_*, O_cmd_rdy             - command stream (op, len = words-1)
//   I_wdata*, O_wdata_rdy          - write word stream into a 1-word holding reg
//   O_rdata*, I_rdata_rdy          - captured read words to the host
//   O_bus_out, O_bus_oe, I_bus_in  - 128-bit bidirectional bus (pad wrapper owns tri-state)
//   O_reset_n, O_spi_sck, O_spi_cs_n, O_in_1, O_in_2, O_OE_req - chip pins
//   O_busy                         - sequencer not idle or chip reset held
//   O_dbg_state                    - current sequencer state (state_e encoding)
//   O_wr_cnt, O_rd_cnt             - saturating word counters, present only
//                                    when FMC_XFER_CNT_EN is defined
//
// Handshakes: every stream uses valid/ready; a beat transfers on a rising
// clk edge where both are high. Valid, once raised, holds its payload
// until the transfer; ready may change freely.
module fmc_link_master
    import fmc_link_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int LEN_W    = LEN_W_DEF,
    parameter int SCK_DIV  = SCK_DIV_DEF,
    parameter int RST_CYC  = RST_CYC_DEF,
    parameter int TURN_CYC = TURN_CYC_DEF
) (
    input  logic             I_clk,
    input  logic             I_rst_n,
    input  logic             I_cmd_val,
    output logic             O_cmd_rdy,
    input  logic [1:0]       I_cmd_op,
    input  logic [LEN_W-1:0] I_cmd_len,
    input  logic [DW-1:0]    I_wdata,
    input  logic             I_wdata_val,
    output logic             O_wdata_rdy,
    output logic [DW-1:0]    O_rdata,
    output logic             O_rdata_val,
    input  logic             I_rdata_rdy,
    output logic [DW-1:0]    O_bus_out,
    output logic             O_bus_oe,
    input  logic [DW-1:0]    I_bus_in,
    output logic             O_reset_n,
    output logic             O_spi_sck,
    output logic             O_spi_cs_n,
    output logic             O_in_1,
    output logic             O_in_2,
    output logic             O_OE_req,
    output logic             O_busy,
    output logic [2:0]       O_dbg_state
`ifdef FMC_XFER_CNT_EN
    ,
    output logic [31:0]      O_wr_cnt,
    output logic [31:0]      O_rd_cnt
`endif
);

    localparam int RCW = $clog2(RST_CYC + 1);
    localparam int TCW = $clog2(TURN_CYC + 1);

    state_e           state, state_next;
    op_e              cmd_op, op_q;
    logic [LEN_W-1:0] len_q, idx_q;
    logic             loaded_q;
    logic             hold_full;
    logic [DW-1:0]    hold_data;
    logic [RCW-1:0]   rst_cnt;
    logic             reset_n_q;
    logic [TCW-1:0]   turn_cnt;

    logic sck_en, sck_freeze, rise_ev, fall_ev, phase_zero;
    logic cmd_acc, is_tx_op, last_word, turn_done, load_now;

    assign cmd_op = op_e'(I_cmd_op);

    fmc_sck_gen #(.SCK_DIV(SCK_DIV)) u_sck (
        .clk        (I_clk),
        .rst_n      (I_rst_n),
        .en         (sck_en),
        .freeze     (sck_freeze),
        .sck        (O_spi_sck),
        .rise_ev    (rise_ev),
        .fall_ev    (fall_ev),
        .phase_zero (phase_zero)
    );

    // Shared control decode.
    always_comb begin
        cmd_acc   = (state == ST_IDLE) && I_cmd_val;
        is_tx_op  = (cmd_op == OP_CFG) || (cmd_op == OP_WR);
        last_word = (idx_q == len_q);
        turn_done = (turn_cnt == TCW'(TURN_CYC - 1));
        sck_en    = (state == ST_XFER) || (state == ST_RD);
        // Write side stalls with no word on the bus; read side stalls at the
        // start of a word period while the previous capture is still unread,
        // so the next rise event can never overwrite it.
        sck_freeze = ((state == ST_XFER) && !loaded_q) ||
                     ((state == ST_RD) && phase_zero && O_rdata_val && !I_rdata_rdy);
        // A word moves from the holding register onto the bus on burst entry,
        // when a stalled burst finally sees data, or at the fall event that
        // ends the previous word.
        load_now = 1'b0;
        if (hold_full) begin
            if (cmd_acc && is_tx_op)
                load_now = 1'b1;
            else if ((state == ST_XFER) && !loaded_q)
                load_now = 1'b1;
            else if ((state == ST_XFER) && fall_ev && !last_word)
                load_now = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) state <= ST_RSTHOLD;
        else          state <= state_next;
    end

    // FSM next state and pin outputs.
    always_comb begin
        state_next  = state;
        O_cmd_rdy   = 1'b0;
        O_bus_oe    = 1'b0;
        O_spi_cs_n  = 1'b1;
        O_in_1      = 1'b0;
        O_in_2      = 1'b0;
        O_OE_req    = 1'b0;
        case (state)
            ST_RSTHOLD: if (reset_n_q) state_next = ST_IDLE;
            ST_IDLE: begin
                O_cmd_rdy = 1'b1;
                if (I_cmd_val) begin
                    case (cmd_op)
                        OP_CFG, OP_WR: state_next = ST_XFER;
                        OP_RD:         state_next = ST_TURN_IN;
                        default:       state_next = ST_DONE;
                    endcase
                end
            end
            ST_XFER: begin
                O_bus_oe   = 1'b1;
                O_spi_cs_n = (op_q != OP_CFG);
                O_in_1     = (op_q == OP_WR);
                if (fall_ev && last_word) state_next = ST_DONE;
            end
            ST_TURN_IN: begin
                O_OE_req = 1'b1;
                if (turn_done) state_next = ST_RD;
            end
            ST_RD: begin
                O_OE_req = 1'b1;
                O_in_2   = 1'b1;
                if (fall_ev && last_word) state_next = ST_TURN_OUT;
            end
            ST_TURN_OUT: begin
                O_OE_req = 1'b1;
                if (turn_done) state_next = ST_DONE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign O_reset_n   = reset_n_q;
    assign O_busy      = (state != ST_IDLE) || !reset_n_q;
    assign O_wdata_rdy = !hold_full;
    assign O_dbg_state = state;

    // Chip reset hold after system reset release.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            rst_cnt   <= '0;
            reset_n_q <= 1'b0;
        end else if (!reset_n_q) begin
            if (rst_cnt == RCW'(RST_CYC - 1)) reset_n_q <= 1'b1;
            else                              rst_cnt   <= rst_cnt + 1'b1;
        end
    end

    // Write holding register and bus drive word. Data accepted outside a
    // burst simply waits here for the next config/write burst.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            hold_full <= 1'b0;
            hold_data <= '0;
            O_bus_out <= '0;
        end else if (load_now) begin
            O_bus_out <= hold_data;
            hold_full <= 1'b0;
        end else if (I_wdata_val && !hold_full) begin
            hold_data <= I_wdata;
            hold_full <= 1'b1;
        end
    end

    // Burst bookkeeping: latched command, word index, bus-word-loaded flag,
    // turnaround counter.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            op_q     <= OP_CFG;
            len_q    <= '0;
            idx_q    <= '0;
            loaded_q <= 1'b0;
            turn_cnt <= '0;
        end else begin
            if (cmd_acc) begin
                op_q     <= cmd_op;
                len_q    <= I_cmd_len;
                idx_q    <= '0;
                loaded_q <= hold_full && is_tx_op;
            end else if (fall_ev && !last_word) begin
                idx_q    <= idx_q + 1'b1;
                loaded_q <= hold_full;
            end else if ((state == ST_XFER) && !loaded_q && hold_full) begin
                loaded_q <= 1'b1;
            end

            if (((state == ST_TURN_IN) || (state == ST_TURN_OUT)) && !turn_done)
                turn_cnt <= turn_cnt + 1'b1;
            else
                turn_cnt <= '0;
        end
    end

    // Read capture. A capture wins over a same-cycle host accept so the new
    // word stays valid.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_rdata     <= '0;
            O_rdata_val <= 1'b0;
        end else if ((state == ST_RD) && rise_ev) begin
            O_rdata     <= I_bus_in;
            O_rdata_val <= 1'b1;
        end else if (I_rdata_rdy) begin
            O_rdata_val <= 1'b0;
        end
    end

`ifdef FMC_XFER_CNT_EN
    // Saturating word counters, cleared only by reset.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_wr_cnt <= '0;
            O_rd_cnt <= '0;
        end else begin
            if ((state == ST_XFER) && fall_ev && (O_wr_cnt != '1))
                O_wr_cnt <= O_wr_cnt + 1'b1;
            if ((state == ST_RD) && rise_ev && (O_rd_cnt != '1))
                O_rd_cnt <= O_rd_cnt + 1'b1;
        end
    end
`endif

endmodule
